// File: rtl/mips_dmem_ctrl.sv
// Big-endian byte/half/word data memory for the MIPS MEM stage: load extension, alignment checks, RD_LATENCY read pipe.
// Define DMEM_CLEAR_ON_RESET_EN to zero-sweep the whole memory after every reset release.
module mips_dmem_ctrl #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic               o_ready,
    output logic               o_rvalid,
    output logic [NB_DATA-1:0] o_rdata,
    output logic               o_misaligned,
    output logic               o_busy
);
    localparam int NB_WIDX = NB_ADDR - 2;
    localparam int WORDS   = 2**NB_WIDX;

`ifdef DMEM_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {ST_RST, ST_CLEAR, ST_IDLE} state_t;
    logic [NB_WIDX-1:0] clr_cnt_q, clr_cnt_d;
`else
    typedef enum logic [1:0] {ST_RST, ST_IDLE} state_t;
`endif
    state_t state_q, state_d;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_RST;
`ifdef DMEM_CLEAR_ON_RESET_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef DMEM_CLEAR_ON_RESET_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            ST_RST: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
                state_d = ST_CLEAR;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef DMEM_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {NB_WIDX{1'b1}})
                    state_d = ST_IDLE;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        o_ready = (state_q == ST_IDLE);
`ifdef DMEM_CLEAR_ON_RESET_EN
        o_busy  = (state_q == ST_CLEAR);
`else
        o_busy  = 1'b0;
`endif
    end

    logic               accept, misaligned, store_ok, clr_wr;
    logic [NB_WIDX-1:0] word_idx, wr_idx;
    logic [7:0]         rd_byte [4];
    logic [31:0]        rd_word, ld_ext, half_sel;
    logic [7:0]         byte_sel;

    assign accept   = i_req & o_ready;
    assign store_ok = accept & i_we & ~misaligned;
    assign word_idx = i_addr[NB_ADDR-1:2];

`ifdef DMEM_CLEAR_ON_RESET_EN
    assign clr_wr = o_busy;
    assign wr_idx = clr_wr ? clr_cnt_q : word_idx;
`else
    assign clr_wr = 1'b0;
    assign wr_idx = word_idx;
`endif

    always_comb begin
        case (i_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = i_addr[0];
            2'b10:   misaligned = |i_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // One byte-wide RAM per lane; lane 0 holds the most significant byte of each word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] mem_q [WORDS];
            logic       lane_be;
            logic [7:0] lane_wd;

            always_comb begin
                lane_be = 1'b0;
                lane_wd = i_wdata[7:0];
                case (i_size)
                    2'b00: lane_be = (i_addr[1:0] == LANE);
                    2'b01: begin
                        lane_be = (i_addr[1] == LANE[1]);
                        lane_wd = LANE[0] ? i_wdata[7:0] : i_wdata[15:8];
                    end
                    2'b10: begin
                        lane_be = 1'b1;
                        lane_wd = i_wdata[8*(3-gi) +: 8];
                    end
                    default: lane_be = 1'b0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (clr_wr)
                    mem_q[wr_idx] <= 8'h00;
                else if (store_ok && lane_be)
                    mem_q[wr_idx] <= lane_wd;
            end

            assign rd_byte[gi] = mem_q[word_idx];
        end
    endgenerate

    assign rd_word  = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
    assign byte_sel = rd_byte[i_addr[1:0]];
    assign half_sel = {16'h0000, (i_addr[1] ? rd_word[15:0] : rd_word[31:16])};

    always_comb begin
        case (i_size)
            2'b00:   ld_ext = {{24{~i_unsigned & byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = {{16{~i_unsigned & half_sel[15]}}, half_sel[15:0]};
            2'b10:   ld_ext = rd_word;
            default: ld_ext = '0;
        endcase
    end

    logic        ld_v, ld_mis, fin_v, fin_mis;
    logic [31:0] ld_data, fin_d;
    assign ld_v    = accept & ~i_we;
    assign ld_mis  = misaligned;
    assign ld_data = misaligned ? 32'h0 : ld_ext;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic        v_q, mis_q;
            logic [31:0] d_q;
            always_ff @(posedge clk or posedge i_rst) begin
                if (i_rst) begin
                    v_q   <= 1'b0;
                    mis_q <= 1'b0;
                    d_q   <= '0;
                end else begin
                    v_q   <= ld_v;
                    mis_q <= ld_mis;
                    d_q   <= ld_data;
                end
            end
            assign fin_v   = v_q;
            assign fin_mis = mis_q;
            assign fin_d   = d_q;
        end else begin : g_lat1
            assign fin_v   = ld_v;
            assign fin_mis = ld_mis;
            assign fin_d   = ld_data;
        end
    endgenerate

    logic        rvalid_q, ld_mis_q, st_mis_q;
    logic [31:0] rdata_q;

    // Store misalignment reports one cycle after acceptance, independent of the load latency.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rvalid_q <= 1'b0;
            ld_mis_q <= 1'b0;
            st_mis_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= fin_v;
            ld_mis_q <= fin_v & fin_mis;
            st_mis_q <= accept & i_we & misaligned;
            if (fin_v)
                rdata_q <= fin_d;
        end
    end

    assign o_rvalid     = rvalid_q;
    assign o_rdata      = rdata_q;
    assign o_misaligned = ld_mis_q | st_mis_q;
endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Randomised and directed bench for mips_dmem_ctrl against a byte-array reference model.
`timescale 1ns/1ps
module tb_mips_dmem_ctrl;
    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int WORDS = (1 << AW) / 4;
`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam int INIT_CYC = 1 + WORDS;
`else
    localparam int INIT_CYC = 1;
`endif

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_req = 1'b0, i_we = 1'b0, i_unsigned = 1'b0;
    logic [1:0]    i_size = 2'b00;
    logic [AW-1:0] i_addr = '0;
    logic [31:0]   i_wdata = '0;
    logic          o_ready, o_rvalid, o_misaligned, o_busy;
    logic [31:0]   o_rdata;

    always #5 clk = ~clk;

    mips_dmem_ctrl #(.NB_DATA(32), .NB_ADDR(AW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_ready(o_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
        .o_misaligned(o_misaligned), .o_busy(o_busy)
    );

    typedef struct packed {
        logic          req;
        logic          we;
        logic [1:0]    sz;
        logic          us;
        logic [AW-1:0] a;
        logic [31:0]   wd;
    } req_t;

    typedef struct packed {
        logic        v;
        logic        mis;
        logic [31:0] d;
    } ld_t;

    int          vecs = 0;
    int          miscmp = 0;
    logic [7:0]  mdl_mem [1 << AW];
    ld_t         pipe_q [$];
    logic [31:0] last_rdata = '0;
    int          init_left = INIT_CYC;

    function automatic req_t mk(input logic req, input logic we, input logic [1:0] sz,
                                input logic us, input int a, input logic [31:0] wd);
        req_t r;
        r.req = req; r.we = we; r.sz = sz; r.us = us; r.a = AW'(a); r.wd = wd;
        return r;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input logic [AW-1:0] a);
        return (sz == 2'd3) || ((int'(a) % nbytes(sz)) != 0);
    endfunction

    // Assemble the big-endian field byte by byte, then sign-extend arithmetically.
    function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic us, input logic [AW-1:0] a);
        int n = nbytes(sz);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl_mem[int'(a) + i]);
        if (!us && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
        return v;
    endfunction

    task automatic mdl_reset();
        pipe_q.delete();
        last_rdata = '0;
        init_left  = INIT_CYC;
`ifdef DMEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = 8'h00;
`endif
    endtask

    // Drive one cycle (called right after a falling edge), advance the model, return observed and expected outputs.
    task automatic run_step(input req_t r, output logic [35:0] obs, output logic [35:0] expv);
        logic acc, smis, busy;
        ld_t  e, outl;
        i_req = r.req; i_we = r.we; i_size = r.sz; i_unsigned = r.us; i_addr = r.a; i_wdata = r.wd;
        acc  = r.req && (init_left == 0);
        e    = '0;
        smis = 1'b0;
        if (acc && !r.we) begin
            e.v   = 1'b1;
            e.mis = is_mis(r.sz, r.a);
            e.d   = e.mis ? 32'h0 : mdl_load(r.sz, r.us, r.a);
        end
        if (acc && r.we) begin
            if (is_mis(r.sz, r.a)) smis = 1'b1;
            else for (int i = 0; i < nbytes(r.sz); i++)
                mdl_mem[int'(r.a) + i] = 8'(r.wd >> (8 * (nbytes(r.sz) - 1 - i)));
        end
        pipe_q.push_back(e);
        outl = '0;
        if (pipe_q.size() >= LAT) outl = pipe_q.pop_front();
        if (init_left > 0) init_left--;
        if (outl.v) last_rdata = outl.d;
        busy = (init_left > 0) && (init_left <= INIT_CYC - 1);
        expv = {(init_left == 0), busy, outl.v, outl.mis | smis, last_rdata};
        @(posedge clk);
        #1;
        obs = {o_ready, o_busy, o_rvalid, o_misaligned, o_rdata};
        $display("[%0t] req=%0b we=%0b sz=%0d us=%0b a=%03h wd=%08h -> rdy=%0b busy=%0b rv=%0b mis=%0b rd=%08h",
                 $time, r.req, r.we, r.sz, r.us, r.a, r.wd, obs[35], obs[34], obs[33], obs[32], obs[31:0]);
        @(negedge clk);
        i_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] obs, ex;
        i_rst = 1'b1;
        #1;
        vecs++;
        if ({o_ready, o_busy, o_rvalid, o_misaligned, o_rdata} !== 36'd0) begin
            miscmp++;
            $display("FAIL reset_async: got %09h expected %09h", {o_ready, o_busy, o_rvalid, o_misaligned, o_rdata}, 36'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if ({o_ready, o_busy, o_rvalid, o_misaligned, o_rdata} !== 36'd0) begin
            miscmp++;
            $display("FAIL reset_held: got %09h expected %09h", {o_ready, o_busy, o_rvalid, o_misaligned, o_rdata}, 36'd0);
        end
        @(negedge clk);
        i_rst = 1'b0;
        mdl_reset();
        #1;
        vecs++;
        if (o_ready !== 1'b0) begin
            miscmp++;
            $display("FAIL reset_release_ready: got %0b expected 0", o_ready);
        end
        for (int i = 0; i < INIT_CYC + 1; i++) begin
            run_step(mk(0, 0, 0, 0, 0, 0), obs, ex);
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL reset_idle: got %09h expected %09h", obs, ex); end
        end
    endtask

    task automatic test_fill();
        logic [35:0] obs, ex;
        for (int w = 0; w < WORDS; w++) begin
            run_step(mk(1, 1, 2, 0, w * 4, $urandom), obs, ex);
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL fill: got %09h expected %09h", obs, ex); end
        end
    endtask

    task automatic test_store_load_word();
        req_t        t [4];
        logic [35:0] obs, ex;
        logic [35:0] got [4];
        t[0] = mk(1, 1, 2, 0, 'h010, 32'hDEADBEEF);
        t[1] = mk(1, 0, 2, 0, 'h010, 0);
        t[2] = mk(0, 0, 0, 0, 0, 0);
        t[3] = mk(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_step(t[i], obs, ex);
            got[i] = obs;
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL store_load_word: got %09h expected %09h", obs, ex); end
        end
        vecs++;
        if ({got[LAT][33], got[LAT][31:0]} !== {1'b1, 32'hDEADBEEF}) begin
            miscmp++;
            $display("FAIL store_load_word_value: got rv=%0b rd=%08h expected rv=1 rd=deadbeef", got[LAT][33], got[LAT][31:0]);
        end
    endtask

    task automatic test_byte_ext();
        req_t        t [6];
        logic [35:0] obs, ex;
        logic [35:0] got [6];
        logic [31:0] want [3];
        want[0] = 32'hFFFFFF80; want[1] = 32'h00000080; want[2] = 32'hDEADBE80;
        t[0] = mk(1, 1, 0, 0, 'h013, 32'h12345680);
        t[1] = mk(1, 0, 0, 0, 'h013, 0);
        t[2] = mk(1, 0, 0, 1, 'h013, 0);
        t[3] = mk(1, 0, 2, 0, 'h010, 0);
        t[4] = mk(0, 0, 0, 0, 0, 0);
        t[5] = mk(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_step(t[i], obs, ex);
            got[i] = obs;
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL byte_ext: got %09h expected %09h", obs, ex); end
        end
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if ({got[LAT + k][33], got[LAT + k][31:0]} !== {1'b1, want[k]}) begin
                miscmp++;
                $display("FAIL byte_ext_value%0d: got rv=%0b rd=%08h expected rv=1 rd=%08h", k, got[LAT + k][33], got[LAT + k][31:0], want[k]);
            end
        end
    endtask

    task automatic test_misaligned();
        req_t        t [6];
        logic [35:0] obs, ex;
        logic [35:0] got [6];
        t[0] = mk(1, 0, 1, 0, 'h011, 0);
        t[1] = mk(1, 0, 2, 0, 'h012, 0);
        t[2] = mk(1, 1, 2, 0, 'h021, 32'hCAFEF00D);
        t[3] = mk(1, 0, 2, 0, 'h020, 0);
        t[4] = mk(1, 0, 3, 1, 'h000, 0);
        t[5] = mk(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_step(t[i], obs, ex);
            got[i] = obs;
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL misaligned: got %09h expected %09h", obs, ex); end
        end
        vecs++;
        if (got[LAT][33:0] !== {1'b1, 1'b1, 32'h0}) begin
            miscmp++;
            $display("FAIL misaligned_half_load: got %09h expected 300000000", got[LAT][33:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] obs, ex;
        logic [5:0]  rv = '0;
        for (int i = 0; i < 6; i++) begin
            run_step((i < 4) ? mk(1, 0, 2, 0, 'h010 + 4 * i, 0) : mk(0, 0, 0, 0, 0, 0), obs, ex);
            rv[i] = obs[33];
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL back_to_back: got %09h expected %09h", obs, ex); end
        end
        vecs++;
        if (rv !== (6'b001111 << (LAT - 1))) begin
            miscmp++;
            $display("FAIL back_to_back_pulses: got %06b expected %06b", rv, 6'b001111 << (LAT - 1));
        end
    endtask

    task automatic test_hazard();
        req_t        t [6];
        logic [35:0] obs, ex;
        t[0] = mk(1, 1, 2, 0, 'h040, 32'h11223344);
        t[1] = mk(1, 0, 2, 0, 'h040, 0);
        t[2] = mk(1, 1, 2, 0, 'h040, 32'h55667788);
        t[3] = mk(1, 0, 1, 0, 'h042, 0);
        t[4] = mk(1, 1, 0, 0, 'h043, 32'h000000AA);
        t[5] = mk(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_step(t[i], obs, ex);
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL hazard: got %09h expected %09h", obs, ex); end
        end
    endtask

    task automatic test_random();
        logic [35:0] obs, ex;
        req_t        r;
        int          a;
        for (int i = 0; i < 400; i++) begin
            r.req = ($urandom_range(0, 9) != 0);
            r.we  = ($urandom_range(0, 9) < 4);
            r.sz  = 2'($urandom_range(0, 3));
            if (r.sz == 2'd3 && $urandom_range(0, 3) != 0) r.sz = 2'd2;
            r.us  = 1'($urandom_range(0, 1));
            a     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, (1 << AW) - 1));
            if ($urandom_range(0, 3) != 0) a = a & ~(nbytes(r.sz) - 1);
            r.a   = AW'(a);
            r.wd  = $urandom;
            run_step(r, obs, ex);
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL random: got %09h expected %09h", obs, ex); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [35:0] obs, ex;
        run_step(mk(1, 0, 2, 0, 'h010, 0), obs, ex);
        vecs++;
        if (obs !== ex) begin miscmp++; $display("FAIL midflight_issue: got %09h expected %09h", obs, ex); end
        i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_addr = AW'('h014);
        @(posedge clk);
        #2;
        i_req = 1'b0;
        i_rst = 1'b1;
        #1;
        vecs++;
        if ({o_ready, o_busy, o_rvalid, o_misaligned, o_rdata} !== 36'd0) begin
            miscmp++;
            $display("FAIL midflight_async: got %09h expected %09h", {o_ready, o_busy, o_rvalid, o_misaligned, o_rdata}, 36'd0);
        end
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        mdl_reset();
        for (int i = 0; i < INIT_CYC + LAT + 1; i++) begin
            run_step(mk(0, 0, 0, 0, 0, 0), obs, ex);
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL midflight_drop: got %09h expected %09h", obs, ex); end
        end
        for (int i = 0; i < LAT + 1; i++) begin
            run_step((i == 0) ? mk(1, 0, 2, 0, 'h010, 0) : mk(0, 0, 0, 0, 0, 0), obs, ex);
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL midflight_retain: got %09h expected %09h", obs, ex); end
        end
    endtask

    task automatic test_reset_during_init();
        logic [35:0] obs, ex;
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        mdl_reset();
        for (int i = 0; i < 5; i++) begin
            run_step(mk(1, 0, 2, 0, 'h004, 0), obs, ex);
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL init_first: got %09h expected %09h", obs, ex); end
        end
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        mdl_reset();
        for (int i = 0; i < INIT_CYC + LAT + 2; i++) begin
            run_step(mk(1, 0, 2, 0, 4 * (i % WORDS), 0), obs, ex);
            vecs++;
            if (obs !== ex) begin miscmp++; $display("FAIL init_restart: got %09h expected %09h", obs, ex); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load_word();
        test_byte_ext();
        test_misaligned();
        test_back_to_back();
        test_hazard();
        test_random();
        test_reset_midflight();
        test_reset_during_init();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule

// File: doc/mips_dmem_ctrl.md
Name: mips_dmem_ctrl

Overview:
Byte-addressable data memory with MIPS load/store semantics for the MEM stage.
- Supports byte, halfword and word accesses, big-endian, with sign or zero extension on loads.
- Registered read path with a parametrised latency and a valid strobe.
- Alignment checking on every access.
- Successor to the plain word-only asynchronous RAM; used as the processor's data memory.

Parameters:
NB_DATA, 32, data width in bits; fixed at 32 (word = 4 bytes), kept for interface consistency.
NB_ADDR, 10, byte-address width; depth = 2**NB_ADDR bytes.
RD_LATENCY, 1, cycles from accepted load to o_rvalid; legal values 1 or 2.

Ports:
clk  input  1  system clock, all state on rising edge
i_rst  input  1  reset; asynchronous, active-high
i_req  input  1  access request, sampled when o_ready=1
i_we  input  1  1 = store, 0 = load
i_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
i_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
i_addr  input  NB_ADDR  byte address
i_wdata  input  NB_DATA  store data; byte/half stores use the low 8/16 bits
o_ready  output  1  block accepts a request this cycle
o_rvalid  output  1  one-cycle strobe qualifying o_rdata
o_rdata  output  NB_DATA  extended load result
o_misaligned  output  1  one-cycle strobe flagging an alignment error
o_busy  output  1  internal initialisation in progress

Behaviour:
- Reset values: o_ready=0 while i_rst=1; o_rvalid=0, o_rdata=0, o_misaligned=0, o_busy=0. The read pipeline is flushed.
- Memory contents are not altered by reset unless the optional feature is enabled.
- States: IDLE, plus CLEAR (feature only). Without the feature: IDLE from the first edge after reset release, with o_ready=1 in IDLE.
- Accept: i_req && o_ready at a rising edge. One access per cycle. Fully pipelined, with no back-pressure in IDLE.
- Byte order: big-endian. Address A holds the MSB of a word.
  - Halfword at A occupies bytes A (high) and A+1.
  - Word at A occupies bytes A..A+3.
- Alignment rules:
  - Halfword requires A[0]=0.
  - Word requires A[1:0]=00.
  - i_size=11 is always misaligned.
- Store, aligned: bytes are written at the accepting edge. A load of the same address accepted on the next cycle returns the new data.
- Store, misaligned: no memory change. o_misaligned=1 for exactly the cycle after acceptance. o_rvalid stays 0.
- Load, aligned: data is captured from memory at the accepting edge. o_rvalid=1 and o_rdata=result exactly RD_LATENCY cycles after acceptance.
  - Byte result: {24 x ext, byte}.
  - Halfword result: {16 x ext, half}.
  - ext = 0 if i_unsigned=1, else the MSB of the loaded field.
- Load, misaligned: o_rvalid and o_misaligned both pulse at the RD_LATENCY slot, with o_rdata=0.
- o_rdata holds its last value when o_rvalid=0.
- Back-to-back loads: one o_rvalid per accepted load, in order, with no bubbles.
- Same-cycle ordering with RD_LATENCY=2: an in-flight load whose address a later store overwrites returns the old data. Data is captured at acceptance.
- No address wrap: alignment guarantees A+3 never exceeds 2**NB_ADDR-1.
- Reset asserted mid-operation: in-flight loads are dropped and produce no o_rvalid. A store accepted on the same edge as reset assertion is not guaranteed.

Optional Feature:
Macro: DMEM_CLEAR_ON_RESET_EN
- Defined:
  - After reset release the FSM enters CLEAR with o_busy=1 and o_ready=0; requests are ignored.
  - It writes zero to one aligned word per cycle, from address 0 upward. This takes 2**NB_ADDR/4 cycles.
  - It then goes to IDLE: o_busy=0, o_ready=1.
  - Reset asserted during CLEAR restarts the sweep from address 0.
- Undefined: the CLEAR state and its counter are absent. o_busy is tied to 0. Memory powers up uninitialised.

Test Plan:
1. Store word 0xDEADBEEF at 0x010, load word 0x010 on the next cycle -> o_rvalid after RD_LATENCY; o_rdata=0xDEADBEEF.
2. Store byte 0x80 at 0x013, then load byte signed / unsigned from 0x013 -> 0xFFFFFF80 / 0x00000080. Word load at 0x010 -> 0xDEADBE80.
3. Load halfword at 0x011 and word at 0x012, and store word at 0x021 -> o_misaligned pulses (loads also pulse o_rvalid with o_rdata=0). Memory at 0x020..0x023 is unchanged.
4. Four back-to-back loads, RD_LATENCY=2 -> four consecutive o_rvalid pulses starting 2 cycles after the first accept, in order.
5. Reset asserted while two loads are in flight -> no o_rvalid. All outputs go to 0 immediately, asynchronously.
6. Feature on, NB_ADDR=6 -> o_busy=1 for 16 cycles after reset, o_ready=0 during it. Afterwards every word reads 0x00000000. Reset mid-sweep -> full 16-cycle sweep again.
